pipe_stage_skid: RTL and testbench

Parametrised pipeline register stage for the dual-issue out-of-order core. It carries a bundle of LANES payload lanes with per-lane valid bits, a valid/ready handshake, a 2-entry skid buffer and a synchronous flush. It replaces fixed always-enabled stage registers between fetch, decode, dispatch and CDB wherever backpressure or mispredict flush is needed. `in_ready` is driven only from registered state, so there is no combinational path from `out_ready` to `in_ready`.

---
 rtl/pipe_stage_skid.sv | 111 +++++++++++
 tb/tb_pipe_stage_skid.sv | 139 +++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline register stage: a LANES-wide bundle with per-lane valids behind a
// valid/ready handshake, a 2-entry (head + skid) buffer and a synchronous flush.
module pipe_stage_skid #(
  parameter int WIDTH = 16,
  parameter int LANES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES-1:0]       in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   in_ready,
  output logic [LANES-1:0]       out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  input  logic                   out_ready,
  input  logic                   flush,
  output logic [1:0]             count
);

  // Handshake: a bundle moves on a rising edge when its side's valid has at
  // least one lane set and the matching ready is high in that cycle. An
  // all-zero valid vector is a bubble and never transfers. in_ready depends
  // only on registered occupancy, never on out_ready.

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [LANES-1:0]       head_valid_q, head_valid_d;
  logic [LANES*WIDTH-1:0] head_data_q,  head_data_d;
  logic [LANES-1:0]       skid_valid_q, skid_valid_d;
  logic [LANES*WIDTH-1:0] skid_data_q,  skid_data_d;

  logic accept;
  logic pop;

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q == ST_EMPTY) ? '0 : head_valid_q;
  assign out_data  = head_data_q;
  assign count     = state_q;

  assign accept = (|in_valid) && in_ready;
  assign pop    = (|out_valid) && out_ready;

  always_comb begin
    state_d      = state_q;
    head_valid_d = head_valid_q;
    head_data_d  = head_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d      = ST_ONE;
          head_valid_d = in_valid;
          head_data_d  = in_data;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          head_valid_d = in_valid;
          head_data_d  = in_data;
        end else if (accept) begin
          state_d      = ST_FULL;
          skid_valid_d = in_valid;
          skid_data_d  = in_data;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d      = ST_ONE;
          head_valid_d = skid_valid_q;
          head_data_d  = skid_data_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flush empties the stage but leaves head data in place so out_data
    // keeps showing the last bundle while idle.
    if (flush) begin
      state_d      = ST_EMPTY;
      head_valid_d = head_valid_q;
      head_data_d  = head_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      head_valid_q <= '0;
      head_data_q  <= '0;
      skid_valid_q <= '0;
      skid_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed plus random bench for pipe_stage_skid: a queue of accepted bundles
// predicts every output bundle, occupancy and ready level.
module tb_pipe_stage_skid;

  localparam int WIDTH = 16;
  localparam int LANES = 2;
  localparam int EW    = LANES * (WIDTH + 1);
  localparam int DW    = LANES * WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic [LANES-1:0] in_valid;
  logic [DW-1:0]    in_data;
  logic             in_ready;
  logic [LANES-1:0] out_valid;
  logic [DW-1:0]    out_data;
  logic             out_ready;
  logic             flush;
  logic [1:0]       count;

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] exp_last;

  always #5 clk = ~clk;

  pipe_stage_skid #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [LANES-1:0] ev;
    logic [DW-1:0]    ed;
    int               sz;
    sz = exp_q.size();
    ev = (sz > 0) ? exp_q[0][EW-1:DW] : '0;
    ed = (sz > 0) ? exp_q[0][DW-1:0]  : exp_last;
    chk({tag, ".count"},     EW'(count),     EW'(sz));
    chk({tag, ".in_ready"},  EW'(in_ready),  EW'(sz != 2));
    chk({tag, ".out_valid"}, EW'(out_valid), EW'(ev));
    chk({tag, ".out_data"},  EW'(out_data),  EW'(ed));
  endtask

  // Drive one cycle of inputs, update the reference model, then check after the edge.
  task automatic step(input string tag, input logic [LANES-1:0] iv, input logic [DW-1:0] id,
                      input logic ordy, input logic fl, input logic rs);
    logic          acc, pp;
    logic [EW-1:0] e;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    acc = (|iv) && (exp_q.size() != 2);
    pp  = (exp_q.size() != 0) && ordy;
    if (exp_q.size() > 0) exp_last = exp_q[0][DW-1:0];
    if (pp) begin
      e = exp_q.pop_front();
      chk({tag, ".pop"}, {out_valid, out_data}, e);
    end
    if (rs) begin
      exp_q.delete();
      exp_last = '0;
    end else if (fl) begin
      exp_q.delete();
    end else begin
      if (acc) exp_q.push_back({iv, id});
      if (exp_q.size() > 0) exp_last = exp_q[0][DW-1:0];
    end
    @(posedge clk);
    @(negedge clk);
    check_state(tag);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; in_valid = '0; in_data = '0;
    exp_last = '0;
    @(negedge clk);
    step("reset0", 2'b00, 32'h0, 1'b0, 1'b0, 1'b1);
    step("reset1", 2'b11, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);

    step("first", 2'b11, {16'hBBBB, 16'hAAAA}, 1'b1, 1'b0, 1'b0);

    for (int i = 1; i <= 8; i++)
      step("stream", 2'b11, {16'h0100 + 16'(i), 16'(i)}, 1'b1, 1'b0, 1'b0);
    step("drain", 2'b00, 32'h0, 1'b1, 1'b0, 1'b0);

    step("bp_a", 2'b01, {16'h0, 16'h0011}, 1'b0, 1'b0, 1'b0);
    step("bp_b", 2'b01, {16'h0, 16'h0022}, 1'b0, 1'b0, 1'b0);
    step("bp_blocked", 2'b11, {16'h0, 16'h0033}, 1'b0, 1'b0, 1'b0);
    step("bp_pop1", 2'b00, 32'h0, 1'b1, 1'b0, 1'b0);
    step("bp_pop2", 2'b00, 32'h0, 1'b1, 1'b0, 1'b0);
    step("idle", 2'b00, 32'h0, 1'b1, 1'b0, 1'b0);

    step("partial", 2'b10, {16'h1234, 16'hDEAD}, 1'b0, 1'b0, 1'b0);
    step("bubble", 2'b00, {16'h5555, 16'h5555}, 1'b0, 1'b0, 1'b0);
    step("partial_pop", 2'b00, 32'h0, 1'b1, 1'b0, 1'b0);

    step("fl_fill1", 2'b01, {16'h0, 16'h0041}, 1'b0, 1'b0, 1'b0);
    step("fl_fill2", 2'b01, {16'h0, 16'h0042}, 1'b0, 1'b0, 1'b0);
    step("flush", 2'b01, {16'h0, 16'h0099}, 1'b1, 1'b1, 1'b0);
    step("post_flush", 2'b00, 32'h0, 1'b1, 1'b0, 1'b0);

    step("rs_fill1", 2'b11, {16'h0051, 16'h0050}, 1'b0, 1'b0, 1'b0);
    step("rs_fill2", 2'b11, {16'h0053, 16'h0052}, 1'b0, 1'b0, 1'b0);
    step("mid_reset", 2'b11, {16'h0055, 16'h0054}, 1'b1, 1'b1, 1'b1);
    step("after_rst", 2'b11, {16'h0061, 16'h0060}, 1'b0, 1'b0, 1'b0);
    step("after_pop", 2'b00, 32'h0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 200; i++)
      step("rand", 2'($urandom_range(0, 3)), 32'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0), 1'b0);
    step("final_drain1", 2'b00, 32'h0, 1'b1, 1'b0, 1'b0);
    step("final_drain2", 2'b00, 32'h0, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
